// File: rtl/single_cycle_core.sv
// Word-addressed MIPS-subset single-cycle core: PC, decoder, controller, 32x32
// register file, 2-bit-op ALU and internal data memory, with control exported.
module single_cycle_core #(
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic [1:0]  alu_op,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] alu_out,
    output logic [31:0] wb_data,
    output logic        zero
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q   [32];
    logic [31:0] rf_d   [32];
    logic [31:0] dmem_q [DMEM_DEPTH];
    logic [31:0] dmem_d [DMEM_DEPTH];

    logic [5:0]    opcode;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [31:0]   sext;
    logic [31:0]   alu_b;
    logic [31:0]   mem_rdata;
    logic [4:0]    wr_addr;
    logic [AW-1:0] dmem_addr;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];
    assign sext   = {{16{imm[15]}}, imm};

    // Main controller; unrecognised opcodes and functs fall through as NOPs.
    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            6'h00: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (instr[5:0])
                    6'h20:   alu_op = 2'b00;
                    6'h22:   alu_op = 2'b01;
                    6'h24:   alu_op = 2'b10;
                    6'h25:   alu_op = 2'b11;
                    default: reg_write = 1'b0;
                endcase
            end
            6'h08: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            6'h23: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            6'h2B: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            6'h04: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            default: ;
        endcase
    end

    assign read_data1 = rf_q[rs];
    assign read_data2 = rf_q[rt];
    assign alu_b      = alu_src ? sext : read_data2;

    always_comb begin
        case (alu_op)
            2'b00:   alu_out = read_data1 + alu_b;
            2'b01:   alu_out = read_data1 - alu_b;
            2'b10:   alu_out = read_data1 & alu_b;
            default: alu_out = read_data1 | alu_b;
        endcase
    end

    assign zero      = (alu_out == 32'd0);
    assign dmem_addr = alu_out[AW-1:0];
    assign mem_rdata = mem_read ? dmem_q[dmem_addr] : 32'd0;
    assign wb_data   = mem_to_reg ? mem_rdata : alu_out;
    assign wr_addr   = reg_dst ? rd : rt;
    assign next_pc   = pc_q + 32'd1 + ((branch && zero) ? sext : 32'd0);
    assign pc        = pc_q;

    // Register 0 is never written, so it keeps its reset value of zero.
    always_comb begin
        pc_d   = next_pc;
        rf_d   = rf_q;
        dmem_d = dmem_q;
        if (reg_write && (wr_addr != 5'd0)) begin
            rf_d[wr_addr] = wb_data;
        end
        if (mem_write) begin
            dmem_d[dmem_addr] = read_data2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            for (int j = 0; j < DMEM_DEPTH; j++) begin
                dmem_q[j] <= 32'd0;
            end
        end else begin
            pc_q   <= pc_d;
            rf_q   <= rf_d;
            dmem_q <= dmem_d;
        end
    end

endmodule

// File: tb/tb_single_cycle_core.sv
// Self-checking bench for single_cycle_core: a program table feeds a scoreboard
// queue, and expected per-cycle outputs are compared at the falling edge.
module tb_single_cycle_core;

    // Control vector order: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
    localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;
    localparam logic [8:0] C_ADD  = 9'b1_0_0_1_0_0_0_00;
    localparam logic [8:0] C_SUB  = 9'b1_0_0_1_0_0_0_01;
    localparam logic [8:0] C_AND  = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_OR   = 9'b1_0_0_1_0_0_0_11;
    localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] C_RNOP = 9'b1_0_0_0_0_0_0_00;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] alu;
        logic [31:0] wb;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc, next_pc;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [31:0] read_data1, read_data2, alu_out, wb_data;
    logic        zero;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t exp_q[$];
    vec_t prog[27];

    single_cycle_core #(.DMEM_DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .pc         (pc),
        .next_pc    (next_pc),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .alu_op     (alu_op),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .alu_out    (alu_out),
        .wb_data    (wb_data),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareField(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    // Drives one instruction and queues what the core must show for it.
    task automatic applyStimulus(input vec_t v);
        instr = v.instr;
        exp_q.push_back(v);
    endtask

    // Samples at the falling edge, then steps to just after the next rising edge.
    task automatic checkOutput();
        vec_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            compareField("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            compareField({e.name, ".pc"}, pc, e.pc);
            compareField({e.name, ".next_pc"}, next_pc, e.next_pc);
            compareField({e.name, ".ctrl"},
                         {23'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op},
                         {23'd0, e.ctrl});
            compareField({e.name, ".read_data1"}, read_data1, e.rd1);
            compareField({e.name, ".alu_out"}, alu_out, e.alu);
            compareField({e.name, ".wb_data"}, wb_data, e.wb);
            compareField({e.name, ".zero"}, {31'd0, zero}, {31'd0, (e.alu == 32'd0)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog[0]  = '{"addi1",   32'h20010005, 32'd0,  32'd1,  C_ADDI, 32'd0,        32'd5,        32'd5};
        prog[1]  = '{"addi2",   32'h2002FFFD, 32'd1,  32'd2,  C_ADDI, 32'd0,        32'hFFFFFFFD, 32'hFFFFFFFD};
        prog[2]  = '{"add",     32'h00221820, 32'd2,  32'd3,  C_ADD,  32'd5,        32'd2,        32'd2};
        prog[3]  = '{"sub",     32'h00212022, 32'd3,  32'd4,  C_SUB,  32'd5,        32'd0,        32'd0};
        prog[4]  = '{"and",     32'h00222824, 32'd4,  32'd5,  C_AND,  32'd5,        32'd5,        32'd5};
        prog[5]  = '{"or",      32'h00223025, 32'd5,  32'd6,  C_OR,   32'd5,        32'hFFFFFFFD, 32'hFFFFFFFD};
        prog[6]  = '{"sw",      32'hAC010003, 32'd6,  32'd7,  C_SW,   32'd0,        32'd3,        32'd3};
        prog[7]  = '{"lw",      32'h8C070003, 32'd7,  32'd8,  C_LW,   32'd0,        32'd3,        32'd5};
        prog[8]  = '{"probe7",  32'hFCE00000, 32'd8,  32'd9,  C_NONE, 32'd5,        32'd5,        32'd5};
        prog[9]  = '{"addi_r0", 32'h20000007, 32'd9,  32'd10, C_ADDI, 32'd0,        32'd7,        32'd7};
        prog[10] = '{"beq_nt",  32'h10220004, 32'd10, 32'd11, C_BEQ,  32'd5,        32'd8,        32'd8};
        prog[11] = '{"beq_b11", 32'h1000FFFE, 32'd11, 32'd10, C_BEQ,  32'd0,        32'd0,        32'd0};
        prog[12] = '{"beq_b10", 32'h1021FFFE, 32'd10, 32'd9,  C_BEQ,  32'd5,        32'd0,        32'd0};
        prog[13] = '{"beq_z0",  32'h10000000, 32'd9,  32'd10, C_BEQ,  32'd0,        32'd0,        32'd0};
        prog[14] = '{"beq_t",   32'h10210004, 32'd10, 32'd15, C_BEQ,  32'd5,        32'd0,        32'd0};
        prog[15] = '{"probe0",  32'hFC000000, 32'd15, 32'd16, C_NONE, 32'd0,        32'd0,        32'd0};
        prog[16] = '{"probe3",  32'hFC600000, 32'd16, 32'd17, C_NONE, 32'd2,        32'd2,        32'd2};
        prog[17] = '{"probe4",  32'hFC800000, 32'd17, 32'd18, C_NONE, 32'd0,        32'd0,        32'd0};
        prog[18] = '{"probe5",  32'hFCA00000, 32'd18, 32'd19, C_NONE, 32'd5,        32'd5,        32'd5};
        prog[19] = '{"probe6",  32'hFCC00000, 32'd19, 32'd20, C_NONE, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
        prog[20] = '{"probe2",  32'hFC400000, 32'd20, 32'd21, C_NONE, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
        prog[21] = '{"rnop",    32'h00000000, 32'd21, 32'd22, C_RNOP, 32'd0,        32'd0,        32'd0};
        prog[22] = '{"sw_wrap", 32'hAC020043, 32'd22, 32'd23, C_SW,   32'd0,        32'h43,       32'h43};
        prog[23] = '{"lw_wrap", 32'h8C080003, 32'd23, 32'd24, C_LW,   32'd0,        32'd3,        32'hFFFFFFFD};
        prog[24] = '{"probe8",  32'hFD000000, 32'd24, 32'd25, C_NONE, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
        prog[25] = '{"addi_rw", 32'h20210001, 32'd25, 32'd26, C_ADDI, 32'd5,        32'd6,        32'd6};
        prog[26] = '{"probe1",  32'hFC200000, 32'd26, 32'd27, C_NONE, 32'd6,        32'd6,        32'd6};

        rst_n = 1'b0;
        instr = 32'h00000000;
        repeat (2) @(posedge clk);
        #1;
        compareField("reset.pc", pc, 32'd0);
        rst_n = 1'b1;

        foreach (prog[k]) begin
            applyStimulus(prog[k]);
            checkOutput();
        end

        // Mid-cycle asynchronous reset must clear pc and $1 without a clock edge.
        instr = 32'hFC200000;
        #2;
        rst_n = 1'b0;
        #1;
        compareField("async_reset.pc", pc, 32'd0);
        compareField("async_reset.r1", read_data1, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus('{"restart_probe1", 32'hFC200000, 32'd0, 32'd1, C_NONE, 32'd0, 32'd0, 32'd0});
        checkOutput();
        applyStimulus('{"restart_addi", 32'h20010005, 32'd1, 32'd2, C_ADDI, 32'd0, 32'd5, 32'd5});
        checkOutput();
        applyStimulus('{"restart_probe1b", 32'hFC200000, 32'd2, 32'd3, C_NONE, 32'd5, 32'd5, 32'd5});
        checkOutput();

        compareField("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
